// File: rtl/oam_dma_if.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma_if
// Brief    : CPU-side and memory-side bus bundle for the OAM DMA engine.
// Revision : 1.0 - initial release
// ============================================================================
interface oam_dma_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d_out;
    logic        cpu_write;
    logic [7:0]  mem_d_in;
    logic [15:0] mem_addr;
    logic [7:0]  mem_d_out;
    logic        mem_write;
    logic        cpu_hold;
    logic        dma_busy;

    // master: CPU/memory environment; slave: the DMA engine
    modport master (
        output cpu_addr, cpu_d_out, cpu_write, mem_d_in,
        input  mem_addr, mem_d_out, mem_write, cpu_hold, dma_busy
    );
    modport slave (
        input  cpu_addr, cpu_d_out, cpu_write, mem_d_in,
        output mem_addr, mem_d_out, mem_write, cpu_hold, dma_busy
    );
endinterface
`default_nettype wire

// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma
// Brief    : Copies one 256-byte page into the OAM data port, stalling the CPU.
// Revision : 1.0 - initial release
// ============================================================================
module oam_dma #(
    parameter logic [15:0] DMA_REG  = 16'h4014,
    parameter logic [15:0] OAM_DATA = 16'h2004
) (
    input wire        clk,
    input wire        rst,
    oam_dma_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic [7:0] r_data;
    logic       r_odd;
    logic       w_trigger;

    assign w_trigger = bus.cpu_write && (bus.cpu_addr == DMA_REG);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_page <= 8'h00;
            r_idx  <= 8'h00;
            r_data <= 8'h00;
            r_odd  <= 1'b0;
        end else begin
            r_odd <= ~r_odd;
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_page <= bus.cpu_d_out;
                        r_idx  <= 8'h00;
                    end
                end
                S_READ:  r_data <= bus.mem_d_in;
                // 8-bit wrap returns idx to 00 after the last byte; page untouched
                S_WRITE: r_idx  <= r_idx + 8'h01;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next        = r_state;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_d_out = bus.cpu_d_out;
        bus.mem_write = bus.cpu_write;
        bus.cpu_hold  = 1'b1;
        bus.dma_busy  = 1'b1;
        case (r_state)
            S_IDLE: begin
                bus.cpu_hold = 1'b0;
                bus.dma_busy = 1'b0;
                if (w_trigger) begin
                    w_next = S_HALT;
                end
            end
            S_HALT: begin
                // odd now means the next cycle is even, so READ can start directly
                w_next = r_odd ? S_READ : S_ALIGN;
            end
            S_ALIGN: begin
                bus.mem_d_out = r_data;
                bus.mem_write = 1'b0;
                w_next        = S_READ;
            end
            S_READ: begin
                bus.mem_addr  = {r_page, r_idx};
                bus.mem_d_out = r_data;
                bus.mem_write = 1'b0;
                w_next        = S_WRITE;
            end
            S_WRITE: begin
                bus.mem_addr  = OAM_DATA;
                bus.mem_d_out = r_data;
                bus.mem_write = 1'b1;
                w_next        = (r_idx == 8'hFF) ? S_IDLE : S_READ;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_oam_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_oam_dma
// Brief    : Self-checking bench: vector table plus randomized transfers vs. a
//            transaction-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oam_dma;
    localparam logic [15:0] DMA_REG  = 16'h4014;
    localparam logic [15:0] OAM_DATA = 16'h2004;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    oam_dma_if bus();
    oam_dma #(.DMA_REG(DMA_REG), .OAM_DATA(OAM_DATA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // memory image: byte at {page,idx} is idx ^ A5
    assign bus.mem_d_in = bus.mem_addr[7:0] ^ 8'hA5;

    typedef enum int {E_HALT, E_ALIGN, E_READ, E_WRITE} ekind_t;
    typedef struct {
        ekind_t      k;
        logic [15:0] a;
        logic [7:0]  d;
    } ent_t;

    // reference: pending busy cycles of the current transfer, front = this cycle
    ent_t        q[$];
    int unsigned cyc      = 0;
    int          nwrites  = 0;
    int          busy_seen = 0;
    int          src_bad  = 0;
    logic [7:0]  cur_page = 8'h00;
    int          nchk = 0;
    int          nerr = 0;

    function automatic void load(input logic [7:0] pg, input bit odd_in_halt);
        ent_t e;
        e.k = E_HALT; e.a = 16'h0000; e.d = 8'h00; q.push_back(e);
        if (!odd_in_halt) begin
            e.k = E_ALIGN; q.push_back(e);
        end
        for (int i = 0; i < 256; i++) begin
            e.k = E_READ;  e.a = {pg, 8'(i)};  e.d = 8'h00;             q.push_back(e);
            e.k = E_WRITE; e.a = OAM_DATA;     e.d = 8'(i) ^ 8'hA5;     q.push_back(e);
        end
    endfunction

    task automatic tick();
        ent_t tmp;
        @(posedge clk);
        if (!rst) begin
            q.delete();
            cyc = 0;
        end else begin
            if (q.size() > 0) begin
                tmp = q.pop_front();
                if (tmp.k == E_WRITE) nwrites++;
            end else if (bus.cpu_write && bus.cpu_addr == DMA_REG) begin
                load(bus.cpu_d_out, ((cyc + 1) % 2) == 1);
            end
            cyc++;
        end
    endtask

    task automatic check();
        logic        eh, ew, dc;
        logic [15:0] ea;
        logic [7:0]  ed;
        eh = 1'b0; ea = bus.cpu_addr; ed = bus.cpu_d_out; ew = bus.cpu_write; dc = 1'b0;
        if (rst && q.size() > 0) begin
            eh = 1'b1;
            case (q[0].k)
                E_HALT:  ;
                E_ALIGN: begin ew = 1'b0; dc = 1'b1; end
                E_READ:  begin ea = q[0].a; ew = 1'b0; dc = 1'b1; end
                default: begin ea = OAM_DATA; ed = q[0].d; ew = 1'b1; end
            endcase
        end
        if (bus.dma_busy === 1'b1) busy_seen++;
        if (bus.dma_busy === 1'b1 && bus.mem_write === 1'b0 && bus.mem_addr !== bus.cpu_addr
            && bus.mem_addr[15:8] !== cur_page) src_bad++;
        nchk++;
        if (bus.cpu_hold !== eh || bus.dma_busy !== eh || bus.mem_addr !== ea ||
            bus.mem_write !== ew || (!dc && bus.mem_d_out !== ed)) begin
            nerr++;
            $display("FAIL bus cyc=%0d got hold=%b busy=%b addr=%h d=%h we=%b want hold=%b addr=%h d=%h we=%b",
                     cyc, bus.cpu_hold, bus.dma_busy, bus.mem_addr, bus.mem_d_out, bus.mem_write,
                     eh, ea, ed, ew);
        end
    endtask

    task automatic cycle(input logic [15:0] a, input logic [7:0] d, input logic w, input logic r);
        @(negedge clk);
        rst = r; bus.cpu_addr = a; bus.cpu_d_out = d; bus.cpu_write = w;
        #1;
        check();
        tick();
    endtask

    task automatic idle_until_parity(input int p);
        for (int i = 0; i < 4 && (cyc % 2) != p; i++) cycle(16'h0000, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic expect_int(input string nm, input int got, input int want);
        nchk++;
        if (got != want) begin
            nerr++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic run_transfer(input logic [7:0] pg, input int retrig_at);
        int          exp_len;
        int          t;
        logic [15:0] a;
        logic [7:0]  d;
        logic        w;
        exp_len   = (((cyc + 1) % 2) == 1) ? 513 : 514;
        cur_page  = pg;
        busy_seen = 0;
        src_bad   = 0;
        cycle(DMA_REG, pg, 1'b1, 1'b1);
        t = 0;
        while (q.size() > 0 && t < 600) begin
            a = 16'($urandom); d = 8'($urandom); w = 1'($urandom);
            if (t == retrig_at)  begin a = DMA_REG; d = 8'h07; w = 1'b1; end
            if (q.size() == 1)   begin a = DMA_REG; d = 8'h09; w = 1'b1; end
            cycle(a, d, w, 1'b1);
            t++;
        end
        expect_int("busy_len", busy_seen, exp_len);
        expect_int("src_page", src_bad, 0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        w;
        logic [15:0] ea;
        logic [7:0]  ed;
        logic        ew;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [15:0] ra;
        int          t;
        vecs[0] = '{16'h0300, 8'h55, 1'b1, 16'h0300, 8'h55, 1'b1};
        vecs[1] = '{16'h4014, 8'h12, 1'b0, 16'h4014, 8'h12, 1'b0};
        vecs[2] = '{16'h4015, 8'h33, 1'b1, 16'h4015, 8'h33, 1'b1};
        vecs[3] = '{16'h2004, 8'hAA, 1'b1, 16'h2004, 8'hAA, 1'b1};
        vecs[4] = '{16'hFFFF, 8'h00, 1'b0, 16'hFFFF, 8'h00, 1'b0};
        vecs[5] = '{16'h0000, 8'hFF, 1'b1, 16'h0000, 8'hFF, 1'b1};

        bus.cpu_addr = 16'h0000; bus.cpu_d_out = 8'h00; bus.cpu_write = 1'b0;
        // reset held, including a write to the trigger address
        cycle(16'h0000, 8'h00, 1'b0, 1'b0);
        cycle(DMA_REG,  8'h02, 1'b1, 1'b0);
        cycle(16'h0000, 8'h00, 1'b0, 1'b1);

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.cpu_addr = vecs[i].a; bus.cpu_d_out = vecs[i].d; bus.cpu_write = vecs[i].w;
            #1;
            nchk++;
            if (bus.mem_addr !== vecs[i].ea || bus.mem_d_out !== vecs[i].ed ||
                bus.mem_write !== vecs[i].ew || bus.dma_busy !== 1'b0 || bus.cpu_hold !== 1'b0) begin
                nerr++;
                $display("FAIL vec%0d got addr=%h d=%h we=%b busy=%b hold=%b want addr=%h d=%h we=%b busy=0 hold=0",
                         i, bus.mem_addr, bus.mem_d_out, bus.mem_write, bus.dma_busy, bus.cpu_hold,
                         vecs[i].ea, vecs[i].ed, vecs[i].ew);
            end
            tick();
        end

        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            if (ra == DMA_REG) ra = 16'h4015;
            cycle(ra, 8'($urandom), 1'($urandom), 1'b1);
        end

        // odd=1 in HALT: no ALIGN, with a retrigger attempt at cycle 100
        idle_until_parity(0);
        run_transfer(8'h02, 100);
        cycle(16'h0000, 8'h00, 1'b0, 1'b1);

        // odd=0 in HALT: one ALIGN cycle
        idle_until_parity(1);
        run_transfer(8'h02, -1);
        // back-to-back on the first idle cycle
        run_transfer(8'h03, 50);
        for (int i = 0; i < 3; i++) cycle(16'h0000, 8'h00, 1'b0, 1'b1);

        // mid-transfer reset after 40 OAM writes
        nwrites  = 0;
        cur_page = 8'h05;
        cycle(DMA_REG, 8'h05, 1'b1, 1'b1);
        t = 0;
        while (nwrites < 40 && t < 200) begin
            cycle(16'h0000, 8'h00, 1'b0, 1'b1);
            t++;
        end
        expect_int("writes_before_reset", nwrites, 40);
        for (int i = 0; i < 3; i++) cycle(16'h0000, 8'h00, 1'b0, 1'b0);
        busy_seen = 0;
        for (int i = 0; i < 10; i++) cycle(16'h0123, 8'h44, 1'b0, 1'b1);
        expect_int("idle_after_reset", busy_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", nchk, nerr);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
